// File: rtl/wb_arbiter.sv
// wb_arbiter: four-master round-robin arbiter for the shared 8-bit Wishbone bus.
// Grants one owner at a time, muxes its request onto the slave port and routes
// ACK/ERR back to that owner only. Ownership lasts while the owner holds CYC.
// Optional feature: define WB_ARB_TIMEOUT_EN to force an error on the owner
// after TIMEOUT unanswered strobe cycles.
module wb_arbiter #(
    parameter int unsigned aw      = 7,
    parameter int unsigned dw      = 7,
    parameter int unsigned sw      = 0,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic [3:0]            M_CYC_I,
    input  logic [3:0]            M_STB_I,
    input  logic [3:0]            M_WE_I,
    input  logic [4*(aw+1)-1:0]   M_ADR_I,
    input  logic [4*(dw+1)-1:0]   M_DAT_I,
    input  logic [4*(sw+1)-1:0]   M_SEL_I,
    output logic [dw:0]           M_DAT_O,
    output logic [3:0]            M_ACK_O,
    output logic [3:0]            M_ERR_O,
    output logic [3:0]            GNT_O,
    output logic [aw:0]           ADR_O,
    output logic [dw:0]           DAT_O,
    output logic [sw:0]           SEL_O,
    output logic                  WE_O,
    output logic                  STB_O,
    output logic                  CYC_O,
    input  logic [dw:0]           DAT_I,
    input  logic                  ACK_I,
    input  logic                  ERR_I
);

    localparam int unsigned NM   = 4;
    localparam int unsigned AW_W = aw + 1;
    localparam int unsigned DW_W = dw + 1;
    localparam int unsigned SW_W = sw + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q,  last_d;
    logic [1:0] cand;
    logic       found;
    logic       stb_c;
    logic       timeout_c;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;

    // Timeout fires only while a transfer is outstanding under an owner.
    assign timeout_c = (state_q == BUSY) && (tcnt_q == TW'(TIMEOUT));
`else
    logic unused_timeout_c;

    assign timeout_c        = 1'b0;
    assign unused_timeout_c = |TIMEOUT;
`endif

    // Read data is broadcast; only ACK/ERR qualify who consumes it.
    assign M_DAT_O = DAT_I;

    // State, owner, round-robin pointer (and timeout counter) registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
`ifdef WB_ARB_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
`endif
        end
    end

    // Next-state, round-robin selection, slave-side mux and response routing.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cand    = 2'd0;
        found   = 1'b0;
        stb_c   = 1'b0;
        GNT_O   = '0;
        CYC_O   = 1'b0;
        STB_O   = 1'b0;
        WE_O    = 1'b0;
        ADR_O   = '0;
        DAT_O   = '0;
        SEL_O   = '0;
        M_ACK_O = '0;
        M_ERR_O = '0;
`ifdef WB_ARB_TIMEOUT_EN
        tcnt_d  = '0;
`endif

        case (state_q)
            IDLE: begin
                // Scan last+1 .. last+4 (mod 4); the pointer wraps onto itself last.
                for (int i = 1; i <= NM; i++) begin
                    cand = last_q + 2'(i);
                    if (!found && M_CYC_I[cand]) begin
                        found   = 1'b1;
                        owner_d = cand;
                    end
                end
                if (found) begin
                    state_d = BUSY;
                end
            end

            BUSY: begin
                stb_c            = M_STB_I[owner_q] & ~timeout_c;
                GNT_O[owner_q]   = 1'b1;
                CYC_O            = M_CYC_I[owner_q];
                STB_O            = stb_c;
                WE_O             = M_WE_I[owner_q];
                ADR_O            = M_ADR_I[owner_q * AW_W +: AW_W];
                DAT_O            = M_DAT_I[owner_q * DW_W +: DW_W];
                SEL_O            = M_SEL_I[owner_q * SW_W +: SW_W];
                M_ACK_O[owner_q] = ACK_I & stb_c & ~ERR_I;
                M_ERR_O[owner_q] = (ERR_I & stb_c) | timeout_c;
`ifdef WB_ARB_TIMEOUT_EN
                if (stb_c && !ACK_I && !ERR_I) begin
                    tcnt_d = TW'(tcnt_q + 1'b1);
                end
`endif
                if (!M_CYC_I[owner_q]) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic, every cycle
// checked against a behavioural round-robin ownership model.
module tb_wb_arbiter;

    localparam int unsigned TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  m_cyc, m_stb, m_we, m_sel;
    logic [31:0] m_adr, m_dat;
    logic [7:0]  dat_i;
    logic        ack_i, err_i;

    logic [7:0]  m_dat_o;
    logic [3:0]  m_ack_o, m_err_o, gnt_o;
    logic [7:0]  adr_o, dat_o;
    logic [0:0]  sel_o;
    logic        we_o, stb_o, cyc_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model: who owns the bus (-1 = nobody), last owner, unanswered-strobe run.
    int m_owner = -1;
    int m_last  = 3;
    int m_run   = 0;

    typedef struct packed {
        logic [3:0] gnt;
        logic       cyc;
        logic       stb;
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
        logic       sel;
        logic [3:0] ack;
        logic [3:0] err;
    } exp_t;

    wb_arbiter #(.aw(7), .dw(7), .sw(0), .TIMEOUT(TMO)) dut (
        .CLK_I  (clk),
        .RST_I  (rst),
        .M_CYC_I(m_cyc),
        .M_STB_I(m_stb),
        .M_WE_I (m_we),
        .M_ADR_I(m_adr),
        .M_DAT_I(m_dat),
        .M_SEL_I(m_sel),
        .M_DAT_O(m_dat_o),
        .M_ACK_O(m_ack_o),
        .M_ERR_O(m_err_o),
        .GNT_O  (gnt_o),
        .ADR_O  (adr_o),
        .DAT_O  (dat_o),
        .SEL_O  (sel_o),
        .WE_O   (we_o),
        .STB_O  (stb_o),
        .CYC_O  (cyc_o),
        .DAT_I  (dat_i),
        .ACK_I  (ack_i),
        .ERR_I  (err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit timeout_now();
`ifdef WB_ARB_TIMEOUT_EN
        return (m_owner >= 0) && (m_run == TMO);
`else
        return 1'b0;
`endif
    endfunction

    // Expected outputs from the current owner and current inputs.
    function automatic exp_t model_out();
        exp_t e;
        bit   tmo;
        e = '0;
        if (m_owner >= 0) begin
            tmo   = timeout_now();
            e.gnt = 4'(1 << m_owner);
            e.cyc = m_cyc[m_owner];
            e.stb = m_stb[m_owner] && !tmo;
            e.we  = m_we[m_owner];
            e.adr = m_adr[8*m_owner +: 8];
            e.dat = m_dat[8*m_owner +: 8];
            e.sel = m_sel[m_owner];
            if (tmo || (e.stb && err_i)) e.err = e.gnt;
            else if (e.stb && ack_i)     e.ack = e.gnt;
        end
        return e;
    endfunction

    // Ownership rules applied at each rising edge.
    always @(posedge clk) begin : model_step
        exp_t e;
        int   k;
        e = model_out();
        if (rst) begin
            m_owner = -1;
            m_last  = 3;
            m_run   = 0;
        end else if (m_owner < 0) begin
            m_run = 0;
            for (int j = 1; j <= 4; j++) begin
                k = (m_last + j) % 4;
                if (m_cyc[k]) begin
                    m_owner = k;
                    break;
                end
            end
        end else begin
            if (e.stb && !ack_i && !err_i) m_run++;
            else                           m_run = 0;
            if (!m_cyc[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_run   = 0;
            end
        end
    end

    // Every-cycle comparison against the model, well clear of the rising edge.
    always begin : compare
        exp_t e;
        @(negedge clk);
        #2;
        if (cmp_en) begin
            e = model_out();
            chk("gnt",   gnt_o,   e.gnt);
            chk("cyc_o", cyc_o,   e.cyc);
            chk("stb_o", stb_o,   e.stb);
            chk("we_o",  we_o,    e.we);
            chk("adr_o", adr_o,   e.adr);
            chk("dat_o", dat_o,   e.dat);
            chk("sel_o", sel_o,   e.sel);
            chk("m_ack", m_ack_o, e.ack);
            chk("m_err", m_err_o, e.err);
            chk("m_dat", m_dat_o, dat_i);
        end
    end

    task automatic pos1();
        @(posedge clk);
        #1;
    endtask

    task automatic neg1();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0;
        m_adr = '0; m_dat = '0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        pos1();
        cmp_en = 1'b1;
        pos1();
        rst = 1'b0;
    endtask

    initial begin : stim
        int idle_cnt;
        bit got;
        int own;
        logic [7:0] wval [3];
        wval[0] = 8'h11; wval[1] = 8'h22; wval[2] = 8'h33;

        rst = 1'b1;
        clear_inputs();
        do_reset();

        // Reset state with no requests.
        neg1();
        chk("rst_gnt", gnt_o, 4'b0000);
        chk("rst_cyc", cyc_o, 1'b0);
        chk("rst_adr", adr_o, 8'h00);

        // Master 2 single read of 0xFF.
        pos1();
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[23:16] = 8'hFF;
        neg1();
        chk("t1_gnt_pre", gnt_o, 4'b0000);
        pos1();
        neg1();
        chk("t1_gnt", gnt_o, 4'b0100);
        chk("t1_adr", adr_o, 8'hFF);
        chk("t1_cyc", cyc_o, 1'b1);
        ack_i = 1'b1; dat_i = 8'hA5;
        #1;
        chk("t1_ack", m_ack_o, 4'b0100);
        chk("t1_mdat", m_dat_o, 8'hA5);
        pos1();
        ack_i = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
        neg1();
        chk("t1_rel_gnt", gnt_o, 4'b0100);
        chk("t1_rel_cyc", cyc_o, 1'b0);
        pos1();
        neg1();
        chk("t1_idle_gnt", gnt_o, 4'b0000);

        // All four request continuously, one ACK each: order 0,1,2,3,0.
        do_reset();
        m_cyc = 4'hF; m_stb = 4'hF;
        for (int k = 0; k < 5; k++) begin
            idle_cnt = 0;
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                neg1();
                if (gnt_o != 4'b0000) got = 1'b1;
                else                  idle_cnt++;
            end
            chk("t2_gnt", gnt_o, 32'(1 << (k % 4)));
            chk("t2_gap", 32'(idle_cnt), 32'd1);
            ack_i = 1'b1;
            pos1();
            ack_i = 1'b0;
            own = k % 4;
            m_cyc[own] = 1'b0; m_stb[own] = 1'b0;
            pos1();
            m_cyc[own] = 1'b1; m_stb[own] = 1'b1;
        end
        clear_inputs();

        // Master 1 burst of three writes while master 0 waits.
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        pos1();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int w = 0; w < 3; w++) begin
            neg1();
            m_dat[15:8] = wval[w];
            ack_i = 1'b1;
            #1;
            chk("t3_gnt", gnt_o, 4'b0010);
            chk("t3_dat", dat_o, wval[w]);
            chk("t3_we", we_o, 1'b1);
            chk("t3_ack", m_ack_o, 4'b0010);
        end
        pos1();
        ack_i = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        neg1();
        chk("t3_rel_gnt", gnt_o, 4'b0010);
        pos1();
        neg1();
        chk("t3_gap_gnt", gnt_o, 4'b0000);
        pos1();
        neg1();
        chk("t3_m0_gnt", gnt_o, 4'b0001);
        pos1();
        m_cyc = '0; m_stb = '0; m_we = '0;
        pos1();
        pos1();

        // ACK and ERR together: ERR wins, ownership persists.
        m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
        pos1();
        ack_i = 1'b1; err_i = 1'b1;
        neg1();
        chk("t4_err", m_err_o, 4'b1000);
        chk("t4_ack", m_ack_o, 4'b0000);
        pos1();
        ack_i = 1'b0; err_i = 1'b0;
        neg1();
        chk("t4_hold1", gnt_o, 4'b1000);
        pos1();
        neg1();
        chk("t4_hold2", gnt_o, 4'b1000);
        pos1();
        m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
        pos1();
        pos1();

        // Leave last=0, then reset during a master 2 write.
        m_cyc[0] = 1'b1;
        pos1();
        m_cyc[0] = 1'b0;
        pos1();
        pos1();
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
        m_adr[23:16] = 8'h3C; m_dat[23:16] = 8'h5A;
        pos1();
        neg1();
        chk("t5_gnt", gnt_o, 4'b0100);
        chk("t5_we", we_o, 1'b1);
        rst = 1'b1;
        pos1();
        neg1();
        chk("t5_rst_gnt", gnt_o, 4'b0000);
        chk("t5_rst_cyc", cyc_o, 1'b0);
        chk("t5_rst_we", we_o, 1'b0);
        chk("t5_rst_adr", adr_o, 8'h00);
        rst = 1'b0;
        m_cyc = 4'b1001; m_stb = 4'b1001; m_we = '0;
        pos1();
        neg1();
        chk("t5_m0_gnt", gnt_o, 4'b0001);
        clear_inputs();
        pos1();
        pos1();

        // Slave never answers: timeout build errors every 16th cycle.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        pos1();
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c <= 40; c++) begin
            neg1();
            chk("t6_stb", stb_o, (c % 16 == 0) ? 1'b0 : 1'b1);
            chk("t6_err", m_err_o, (c % 16 == 0) ? 4'b0010 : 4'b0000);
        end
`else
        for (int c = 1; c <= 100; c++) begin
            neg1();
            chk("t6_stb", stb_o, 1'b1);
            chk("t6_err", m_err_o, 4'b0000);
        end
`endif
        clear_inputs();
        pos1();
        pos1();

        // Randomized traffic, checked only by the model comparison.
        for (int cyc_n = 0; cyc_n < 4000; cyc_n++) begin
            pos1();
            rst = ($urandom_range(0, 299) == 0);
            for (int n = 0; n < 4; n++) begin
                if (m_cyc[n]) begin
                    if ($urandom_range(0, 7) == 0) m_cyc[n] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) m_cyc[n] = 1'b1;
                end
                m_stb[n] = m_cyc[n] & 1'($urandom_range(0, 3) != 0);
                m_we[n]  = 1'($urandom_range(0, 1));
                m_sel[n] = 1'($urandom_range(0, 1));
                m_adr[8*n +: 8] = 8'($urandom);
                m_dat[8*n +: 8] = 8'($urandom);
            end
            ack_i = ($urandom_range(0, 2) == 0);
            err_i = ($urandom_range(0, 9) == 0);
            dat_i = 8'($urandom);
        end

        rst = 1'b0;
        clear_inputs();
        pos1();
        pos1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
